// File: rtl/rv32i_types.sv
// Shared types for the out-of-order core: the reorder buffer entry layout.
package rv32i_types;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic        regwrite;
        logic        mispredict;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic [31:0] target;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates tags at the tail, collects CDB results,
// retires one done entry per cycle from the head and raises a flush on mispredict.
module reorder_buffer
    import rv32i_types::*;
#(
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    input  logic                 alloc_regwrite,
    input  logic [4:0]           alloc_rd_s,
    output logic [ROB_IDX_W-1:0] alloc_rob,
    input  logic                 wb_valid,
    input  logic [ROB_IDX_W-1:0] wb_rob,
    input  logic [31:0]          wb_rd_v,
    input  logic                 wb_mispredict,
    input  logic [31:0]          wb_target,
    input  logic [ROB_IDX_W-1:0] rs1_q_rob,
    output logic                 rs1_q_ready,
    output logic [31:0]          rs1_q_v,
    input  logic [ROB_IDX_W-1:0] rs2_q_rob,
    output logic                 rs2_q_ready,
    output logic [31:0]          rs2_q_v,
    output logic                 commit_valid,
    output logic                 commit_regfile_we,
    output logic [4:0]           commit_rd_s,
    output logic [31:0]          commit_rd_v,
    output logic [ROB_IDX_W-1:0] commit_rob,
    output logic                 move_flush,
    output logic [31:0]          flush_pc
);

    localparam int                 DEPTH   = 1 << ROB_IDX_W;
    localparam logic [ROB_IDX_W:0] PTR_ONE = 1;

    rob_entry_t             rob [DEPTH];
    logic [ROB_IDX_W:0]     head;
    logic [ROB_IDX_W:0]     tail;
    logic [ROB_IDX_W-1:0]   head_idx;
    logic [ROB_IDX_W-1:0]   tail_idx;
    rob_entry_t             head_e;
    rob_entry_t             new_e;
    logic                   full;
    logic                   alloc_fire;

    assign head_idx = head[ROB_IDX_W-1:0];
    assign tail_idx = tail[ROB_IDX_W-1:0];
    assign head_e   = rob[head_idx];

    // Same index with opposite wrap bits means the tail has lapped the head.
    assign full       = (head_idx == tail_idx) && (head[ROB_IDX_W] != tail[ROB_IDX_W]);
    assign alloc_ready = !full && !move_flush;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_rob   = tail_idx;

    assign commit_valid      = head_e.valid && head_e.done;
    assign commit_regfile_we = commit_valid && head_e.regwrite;
    assign commit_rd_s       = commit_valid ? head_e.rd_s : 5'd0;
    assign commit_rd_v       = commit_valid ? head_e.rd_v : 32'd0;
    assign commit_rob        = head_idx;
    assign move_flush        = commit_valid && head_e.mispredict;
    assign flush_pc          = move_flush ? head_e.target : 32'd0;

    assign rs1_q_ready = rob[rs1_q_rob].valid && rob[rs1_q_rob].done;
    assign rs1_q_v     = rs1_q_ready ? rob[rs1_q_rob].rd_v : 32'd0;
    assign rs2_q_ready = rob[rs2_q_rob].valid && rob[rs2_q_rob].done;
    assign rs2_q_v     = rs2_q_ready ? rob[rs2_q_rob].rd_v : 32'd0;

    always_comb begin
        new_e          = '0;
        new_e.valid    = 1'b1;
        new_e.regwrite = alloc_regwrite;
        new_e.rd_s     = alloc_rd_s;
    end

    // Writeback is applied first so a retiring head's clear takes precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob[i] <= '0;
            end
        end else if (move_flush) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob[i] <= '0;
            end
        end else begin
            if (wb_valid && rob[wb_rob].valid) begin
                rob[wb_rob].done       <= 1'b1;
                rob[wb_rob].rd_v       <= wb_rd_v;
                rob[wb_rob].mispredict <= wb_mispredict;
                rob[wb_rob].target     <= wb_target;
            end
            if (commit_valid) begin
                rob[head_idx] <= '0;
                head          <= head + PTR_ONE;
            end
            if (alloc_fire) begin
                rob[tail_idx] <= new_e;
                tail          <= tail + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a random run
// compared against a queue-based model of the retirement order.
module tb_reorder_buffer;

    localparam int W     = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic          alloc_ready;
    logic          alloc_regwrite;
    logic [4:0]    alloc_rd_s;
    logic [W-1:0]  alloc_rob;
    logic          wb_valid;
    logic [W-1:0]  wb_rob;
    logic [31:0]   wb_rd_v;
    logic          wb_mispredict;
    logic [31:0]   wb_target;
    logic [W-1:0]  rs1_q_rob;
    logic          rs1_q_ready;
    logic [31:0]   rs1_q_v;
    logic [W-1:0]  rs2_q_rob;
    logic          rs2_q_ready;
    logic [31:0]   rs2_q_v;
    logic          commit_valid;
    logic          commit_regfile_we;
    logic [4:0]    commit_rd_s;
    logic [31:0]   commit_rd_v;
    logic [W-1:0]  commit_rob;
    logic          move_flush;
    logic [31:0]   flush_pc;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_IDX_W(W)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_regwrite(alloc_regwrite), .alloc_rd_s(alloc_rd_s), .alloc_rob(alloc_rob),
        .wb_valid(wb_valid), .wb_rob(wb_rob), .wb_rd_v(wb_rd_v),
        .wb_mispredict(wb_mispredict), .wb_target(wb_target),
        .rs1_q_rob(rs1_q_rob), .rs1_q_ready(rs1_q_ready), .rs1_q_v(rs1_q_v),
        .rs2_q_rob(rs2_q_rob), .rs2_q_ready(rs2_q_ready), .rs2_q_v(rs2_q_v),
        .commit_valid(commit_valid), .commit_regfile_we(commit_regfile_we),
        .commit_rd_s(commit_rd_s), .commit_rd_v(commit_rd_v), .commit_rob(commit_rob),
        .move_flush(move_flush), .flush_pc(flush_pc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: program-order queue of live tags plus per-tag result records.
    int          m_q[$];
    int          m_head;
    bit          m_done [DEPTH];
    bit          m_rw   [DEPTH];
    bit          m_mis  [DEPTH];
    logic [4:0]  m_rd   [DEPTH];
    logic [31:0] m_v    [DEPTH];
    logic [31:0] m_tgt  [DEPTH];

    function automatic bit in_q(input int t);
        foreach (m_q[i]) if (m_q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready(input int t);
        return in_q(t) && m_done[t];
    endfunction

    logic          obs_ready, obs_commit, obs_we, obs_flush, obs_rs1_ready, obs_rs2_ready;
    logic [W-1:0]  obs_alloc_rob;
    logic [4:0]    obs_rd_s;
    logic [31:0]   obs_rd_v, obs_flush_pc, obs_rs1_v;

    task automatic drive_idle();
        alloc_valid = 0; alloc_regwrite = 0; alloc_rd_s = 0;
        wb_valid = 0; wb_rob = 0; wb_rd_v = 0; wb_mispredict = 0; wb_target = 0;
        rs1_q_rob = 0; rs2_q_rob = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        m_q.delete();
        m_head = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_alloc_ready", alloc_ready, 1);
        check_eq("rst_alloc_rob", alloc_rob, 0);
        check_eq("rst_commit_valid", commit_valid, 0);
        check_eq("rst_commit_we", commit_regfile_we, 0);
        check_eq("rst_commit_rd", {commit_rd_s, commit_rd_v[26:0]} | commit_rd_v, 0);
        check_eq("rst_commit_rob", commit_rob, 0);
        check_eq("rst_flush", {move_flush, flush_pc[30:0]} | flush_pc, 0);
        check_eq("rst_lookup", {rs1_q_ready, rs2_q_ready} | rs1_q_v | rs2_q_v, 0);
        rst = 1'b0;
    endtask

    // One cycle: drive inputs after the falling edge, compare against the model,
    // then advance the model across the rising edge.
    task automatic step(input logic av = 0, input logic rw = 0, input logic [4:0] rd = 0,
                        input logic wv = 0, input logic [W-1:0] wr = 0, input logic [31:0] wval = 0,
                        input logic wmis = 0, input logic [31:0] wtgt = 0,
                        input logic [W-1:0] q1 = 0, input logic [W-1:0] q2 = 0);
        int  sz, hd, e_tail;
        bit  e_commit, e_flush, e_ready, wb_hit;
        alloc_valid = av; alloc_regwrite = rw; alloc_rd_s = rd;
        wb_valid = wv; wb_rob = wr; wb_rd_v = wval; wb_mispredict = wmis; wb_target = wtgt;
        rs1_q_rob = q1; rs2_q_rob = q2;
        #1;
        sz       = m_q.size();
        hd       = (sz > 0) ? m_q[0] : 0;
        e_commit = (sz > 0) && m_done[hd];
        e_flush  = e_commit && m_mis[hd];
        e_ready  = (sz < DEPTH) && !e_flush;
        e_tail   = (m_head + sz) % DEPTH;
        check_eq("alloc_ready", alloc_ready, e_ready);
        check_eq("alloc_rob", alloc_rob, e_tail);
        check_eq("commit_valid", commit_valid, e_commit);
        check_eq("move_flush", move_flush, e_flush);
        check_eq("commit_rob", commit_rob, m_head);
        if (e_commit) begin
            check_eq("commit_we", commit_regfile_we, m_rw[hd]);
            check_eq("commit_rd_s", commit_rd_s, m_rd[hd]);
            check_eq("commit_rd_v", commit_rd_v, m_v[hd]);
        end
        if (e_flush) check_eq("flush_pc", flush_pc, m_tgt[hd]);
        check_eq("rs1_q_ready", rs1_q_ready, m_ready(q1));
        check_eq("rs1_q_v", rs1_q_v, m_ready(q1) ? m_v[q1] : 32'd0);
        check_eq("rs2_q_ready", rs2_q_ready, m_ready(q2));
        check_eq("rs2_q_v", rs2_q_v, m_ready(q2) ? m_v[q2] : 32'd0);
        obs_ready = alloc_ready; obs_commit = commit_valid; obs_we = commit_regfile_we;
        obs_flush = move_flush; obs_flush_pc = flush_pc; obs_alloc_rob = alloc_rob;
        obs_rd_s = commit_rd_s; obs_rd_v = commit_rd_v;
        obs_rs1_ready = rs1_q_ready; obs_rs1_v = rs1_q_v; obs_rs2_ready = rs2_q_ready;
        wb_hit = wv && in_q(wr);
        @(posedge clk);
        if (e_flush) begin
            m_q.delete();
            m_head = 0;
        end else begin
            if (wb_hit) begin
                m_done[wr] = 1; m_v[wr] = wval; m_mis[wr] = wmis; m_tgt[wr] = wtgt;
            end
            if (e_commit) begin
                void'(m_q.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
            if (av && e_ready) begin
                m_q.push_back(e_tail);
                m_done[e_tail] = 0; m_mis[e_tail] = 0;
                m_rw[e_tail] = rw; m_rd[e_tail] = rd;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int live[$];
        drive_idle();
        rst = 1'b1;
        @(negedge clk);

        // Fill with no writeback.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 5'(i));
            check_eq("fill_tag", obs_alloc_rob, i);
            check_eq("fill_no_commit", obs_commit, 0);
        end
        step();
        check_eq("fill_full_ready", obs_ready, 0);
        check_eq("fill_full_commit", obs_commit, 0);

        // Out-of-order writeback, in-order commit.
        do_reset();
        step(1, 1, 5);
        step(1, 1, 6);
        step(0, 0, 0, 1, 1, 32'h22);
        step(0, 0, 0, 1, 0, 32'h11);
        step();
        check_eq("ord_c0_valid", obs_commit, 1);
        check_eq("ord_c0_rd", obs_rd_s, 5);
        check_eq("ord_c0_v", obs_rd_v, 32'h11);
        step();
        check_eq("ord_c1_valid", obs_commit, 1);
        check_eq("ord_c1_rd", obs_rd_s, 6);
        check_eq("ord_c1_v", obs_rd_v, 32'h22);
        step();
        check_eq("ord_empty", obs_commit, 0);

        // Store retires without a register write.
        do_reset();
        step(1, 0, 7);
        step(0, 0, 0, 1, 0, 32'h5);
        step();
        check_eq("store_commit", obs_commit, 1);
        check_eq("store_we", obs_we, 0);

        // Mispredict flush.
        do_reset();
        repeat (3) step(1, 1, 9);
        step(0, 0, 0, 1, 0, 32'h44, 1, 32'h60);
        step(1, 1, 3);
        check_eq("flush_raised", obs_flush, 1);
        check_eq("flush_target", obs_flush_pc, 32'h60);
        check_eq("flush_jal_commit", obs_we, 1);
        check_eq("flush_no_alloc", obs_ready, 0);
        step(0, 0, 0, 1, 2, 32'h99);
        check_eq("post_flush_tag", obs_alloc_rob, 0);
        check_eq("post_flush_drop", obs_flush, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        check_eq("late_wb_ignored", obs_rs1_ready, 0);
        check_eq("post_flush_empty", obs_commit, 0);

        // Wrap-around: fill, retire ten, refill.
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 1, 5'(i + 1));
        for (int t = 9; t >= 0; t--) step(0, 0, 0, 1, 4'(t), 32'h100 + t);
        for (int i = 0; i < 14; i++) step(1, 1, 5'(20 + i));
        check_eq("wrap_full", obs_ready, 0);
        check_eq("wrap_tail", obs_alloc_rob, 10);
        live = m_q;
        foreach (live[i]) step(0, 0, 0, 1, 4'(live[i]), $urandom);
        repeat (20) step();
        check_eq("wrap_drained", obs_commit, 0);

        // Operand lookup.
        do_reset();
        repeat (4) step(1, 1, 1);
        step(0, 0, 0, 1, 3, 32'hABCD);
        step(0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
        check_eq("look_ready", obs_rs1_ready, 1);
        check_eq("look_v", obs_rs1_v, 32'hABCD);
        check_eq("look_notdone", obs_rs2_ready, 0);

        // Random traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [W-1:0] wr;
            int sz = m_q.size();
            if (sz > 0 && $urandom_range(0, 3) != 0) wr = 4'(m_q[$urandom_range(0, sz - 1)]);
            else wr = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 9) < 6), 1'($urandom), 5'($urandom),
                 ($urandom_range(0, 9) < 5), wr, $urandom,
                 ($urandom_range(0, 15) == 0), $urandom,
                 4'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
